display_scheduler: RTL and testbench
====================================

Name: display_scheduler

Overview:
Controller that shares the 2-digit multiplexed 7-segment display driver between four 8-bit display sources (e.g. PC, accumulator, ALU result, IO value).
- Generates the driver's refresh enable tick (Cen).
- Rotates the selected source on a dwell timer.
- Grants a hold request that pins one source on the display.
- Sits between the CPU datapath and the display refresh block; OutD feeds the refresh block's InD, Cen feeds its Cen.

Parameters:
PRESCALE, 50000, Clk cycles per Cen pulse (>=2)
DWELL, 256, Cen pulses each source is shown while scanning (>=1)

Ports:
Clk  input  1  system clock, rising edge
Rst_n  input  1  asynchronous active-low reset
Src0  input  8  display source 0
Src1  input  8  display source 1
Src2  input  8  display source 2
Src3  input  8  display source 3
Src_en  input  4  bit i = source i takes part in rotation
Hold_req  input  1  request to pin a source
Hold_src  input  2  source index to pin while Hold_req=1
Hold_ack  output  1  hold granted (high while in HOLD)
Cen  output  1  one-Clk refresh enable pulse to display driver
Sel  output  2  currently selected source index
OutD  output  8  selected source value to display driver InD

Behaviour:
- Reset (Rst_n low, async): prescaler=0, dwell=0, state=IDLE, Sel=0, OutD=8'h00, Cen=0, Hold_ack=0. Every output is driven to its reset value immediately, including mid-operation.
- Prescaler: counts 0..PRESCALE-1 and wraps. Cen=1 for exactly one cycle when the count equals PRESCALE-1. The first pulse comes PRESCALE cycles after reset release. The prescaler free-runs in every state.
- Dwell counter: counts Cen pulses in SCAN only. Cleared on every Sel change and on every state entry. Expiry = the DWELL-th Cen pulse.
- Counter widths: $clog2 of the parameter, minimum 1 bit.
- OutD is registered: OutD <= Src[Sel] every cycle in SCAN/HOLD, so it lags Sel by 1 cycle. OutD=8'h00 in IDLE.
- "Next enabled" = the first set Src_en bit searching upward from Sel+1, wrapping 3->0. If Sel's own bit is the only one set, Sel remains.
- State IDLE:
  - Src_en!=0 -> SCAN, Sel=lowest set index.
  - Hold_req=1 -> HOLD; this takes priority over Src_en.
- State SCAN:
  - Hold_req=1 -> HOLD, Sel=Hold_src. This has priority over dwell expiry in the same cycle.
  - Else Src_en==0 -> IDLE, Sel unchanged.
  - Else Src_en[Sel]==0 -> Sel=next enabled on the next cycle.
  - Else dwell expiry -> Sel=next enabled.
- State HOLD:
  - Hold_ack=1.
  - Sel tracks Hold_src with 1-cycle latency, even for sources disabled in Src_en.
  - Hold_req=0 -> SCAN (Sel unchanged if enabled, else next enabled) or IDLE if Src_en==0. Hold_ack falls on the same edge.
- Hold latency: Hold_req sampled high at edge T -> Hold_ack=1 and Sel=Hold_src after T; OutD=Src[Hold_src] after T+1.
- Source data changing while selected propagates to OutD within 1 cycle; there is no latching per dwell.

Optional Feature:
Macro DISP_BLANK_EN.
- Defined: adds state BLANK. Every dwell-expiry Sel change in SCAN goes SCAN->BLANK with the new Sel, which lasts until the next Cen pulse. During BLANK, OutD=8'h00 and the dwell counter is held at 0; the next Cen moves the state to SCAN.
  - Hold_req in BLANK -> HOLD, same as from SCAN.
  - Src_en==0 in BLANK -> IDLE.
- Not defined: Sel changes go directly SCAN->SCAN with no blank interval; BLANK state logic is absent.

Test Plan:
1. PRESCALE=4, DWELL=2, Src_en=0, release Rst_n -> Cen high on cycles 4,8,12...; OutD=00; Hold_ack=0; Sel=0.
2. Src_en=4'b1011, Src0=11, Src1=22, Src3=44 -> Sel 0,1,3,0 and OutD 11,22,44,11, each held 8 cycles (2 Cen periods); index 2 never selected.
3. While scanning, Hold_req=1, Hold_src=2, Src2=33 -> Hold_ack=1 next cycle, OutD=33 the cycle after, unchanged through 5 Cen pulses. Drop Hold_req -> Hold_ack=0, no-hold state SCAN, rotation resumes from source 3.
4. Hold_req rises in the same cycle as dwell expiry -> state HOLD, Sel=Hold_src, no rotation step. Clear Src_en[Sel] mid-scan -> Sel advances 1 cycle later.
5. Rst_n pulsed low mid-scan for 1 cycle, asynchronously (between edges) -> Cen=0, OutD=00, Sel=0, Hold_ack=0 immediately. After release, first Cen comes 4 cycles later.
6. DISP_BLANK_EN defined, scenario 2 stimulus -> OutD=00 for 4 cycles after each switch, then the new value for 8 cycles.

Source files
------------

// File: rtl/display_scheduler.sv
// Display source scheduler: shares a 2-digit 7-segment refresh driver between four
// 8-bit sources. Optional blank interval between sources is built when DISP_BLANK_EN is defined.
module display_scheduler #(
   parameter int PRESCALE = 50000,
   parameter int DWELL    = 256
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic [7:0] Src0,
   input  logic [7:0] Src1,
   input  logic [7:0] Src2,
   input  logic [7:0] Src3,
   input  logic [3:0] Src_en,
   input  logic       Hold_req,
   input  logic [1:0] Hold_src,
   output logic       Hold_ack,
   output logic       Cen,
   output logic [1:0] Sel,
   output logic [7:0] OutD
);

   // state | meaning
   // IDLE  | no source enabled, display shows 00
   // SCAN  | rotating through enabled sources on the dwell timer
   // HOLD  | one source pinned by Hold_req
   // BLANK | display dark until the next Cen after a rotation step

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
   localparam logic [DW-1:0] D_LAST = DW'(DWELL - 1);

`ifdef DISP_BLANK_EN
   typedef enum logic [1:0] {IDLE, SCAN, HOLD, BLANK} state_t;
`else
   typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
`endif

   state_t          state, state_n;
   logic [1:0]      sel, sel_n;
   logic [PW-1:0]   pcnt;
   logic [DW-1:0]   dcnt;
   logic [7:0]      out_d;
   logic [7:0]      src_sel;
   logic [1:0]      sel_next_en;
   logic [1:0]      sel_lowest;
   logic            cen;
   logic            expire;
   logic            any_en;

   function automatic logic [1:0] next_enabled(input logic [1:0] cur, input logic [3:0] en);
      logic [1:0] idx;
      logic [1:0] res;
      res = cur;
      // Walk downward so the closest upward neighbour is the last one written.
      for (int i = 3; i >= 1; i--) begin
         idx = cur + 2'(i);
         if (en[idx]) res = idx;
      end
      return res;
   endfunction

   function automatic logic [1:0] lowest_enabled(input logic [3:0] en);
      logic [1:0] res;
      res = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (en[i]) res = 2'(i);
      end
      return res;
   endfunction

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)              pcnt <= '0;
      else if (pcnt == P_LAST) pcnt <= '0;
      else                     pcnt <= pcnt + PW'(1);
   end

   assign cen         = (pcnt == P_LAST);
   assign any_en      = |Src_en;
   assign expire      = (state == SCAN) && cen && (dcnt == D_LAST);
   assign sel_next_en = next_enabled(sel, Src_en);
   assign sel_lowest  = lowest_enabled(Src_en);

   always_comb begin
      src_sel = 8'h00;
      case (sel)
         2'd0: src_sel = Src0;
         2'd1: src_sel = Src1;
         2'd2: src_sel = Src2;
         2'd3: src_sel = Src3;
         default: src_sel = 8'h00;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state <= IDLE;
         sel   <= 2'd0;
      end else begin
         state <= state_n;
         sel   <= sel_n;
      end
   end

   always_comb begin
      state_n = state;
      sel_n   = sel;
      case (state)
         IDLE: begin
            if (Hold_req) begin
               state_n = HOLD;
               sel_n   = Hold_src;
            end else if (any_en) begin
               state_n = SCAN;
               sel_n   = sel_lowest;
            end
         end
         SCAN: begin
            if (Hold_req) begin
               state_n = HOLD;
               sel_n   = Hold_src;
            end else if (!any_en) begin
               state_n = IDLE;
            end else if (!Src_en[sel]) begin
               sel_n = sel_next_en;
            end else if (expire) begin
               sel_n = sel_next_en;
`ifdef DISP_BLANK_EN
               if (sel_next_en != sel) state_n = BLANK;
`endif
            end
         end
         HOLD: begin
            if (Hold_req) begin
               sel_n = Hold_src;
            end else if (!any_en) begin
               state_n = IDLE;
            end else begin
               state_n = SCAN;
               if (!Src_en[sel]) sel_n = sel_next_en;
            end
         end
`ifdef DISP_BLANK_EN
         BLANK: begin
            if (Hold_req) begin
               state_n = HOLD;
               sel_n   = Hold_src;
            end else if (!any_en) begin
               state_n = IDLE;
            end else begin
               if (!Src_en[sel]) sel_n = sel_next_en;
               if (cen) state_n = SCAN;
            end
         end
`endif
         default: begin
            state_n = IDLE;
            sel_n   = 2'd0;
         end
      endcase
   end

   // Dwell restarts whenever the shown source or the state changes, so each source gets a full period.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)
         dcnt <= '0;
      else if ((state != SCAN) || (state_n != state) || (sel_n != sel))
         dcnt <= '0;
      else if (cen)
         dcnt <= (dcnt == D_LAST) ? '0 : dcnt + DW'(1);
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)                              out_d <= 8'h00;
      else if (state == SCAN || state == HOLD) out_d <= src_sel;
      else                                     out_d <= 8'h00;
   end

   assign Cen      = cen;
   assign Sel      = sel;
   assign OutD     = out_d;
   assign Hold_ack = (state == HOLD);

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: table of input segments with expected outputs per cycle,
// expectations queued on drive and popped on sampling, plus a hand-written async reset sequence.
module tb_display_scheduler;
   localparam int PRESCALE = 4;
   localparam int DWELL    = 2;

   logic       Clk = 1'b0;
   logic       Rst_n = 1'b0;
   logic [7:0] Src0, Src1, Src2, Src3;
   logic [3:0] Src_en;
   logic       Hold_req;
   logic [1:0] Hold_src;
   logic       Hold_ack;
   logic       Cen;
   logic [1:0] Sel;
   logic [7:0] OutD;

   display_scheduler #(.PRESCALE(PRESCALE), .DWELL(DWELL)) dut (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .Src0     (Src0),
      .Src1     (Src1),
      .Src2     (Src2),
      .Src3     (Src3),
      .Src_en   (Src_en),
      .Hold_req (Hold_req),
      .Hold_src (Hold_src),
      .Hold_ack (Hold_ack),
      .Cen      (Cen),
      .Sel      (Sel),
      .OutD     (OutD)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [3:0] en;
      logic       hreq;
      logic [1:0] hsrc;
      int         n;
      logic [1:0] sel;
      logic [7:0] outd;
      logic       ack;
   } row_t;

   typedef struct packed {
      logic [1:0] sel;
      logic [7:0] outd;
      logic       ack;
      logic       cen;
   } exp_t;

   row_t tbl[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   ncyc   = 0;

   function automatic void add(input logic [3:0] en, input logic hreq, input logic [1:0] hsrc,
                               input int n, input logic [1:0] sel, input logic [7:0] outd,
                               input logic ack);
      row_t r;
      r.en = en; r.hreq = hreq; r.hsrc = hsrc; r.n = n;
      r.sel = sel; r.outd = outd; r.ack = ack;
      tbl.push_back(r);
   endfunction

   task automatic run_row(input row_t r, input int id);
      exp_t e;
      Src_en   = r.en;
      Hold_req = r.hreq;
      Hold_src = r.hsrc;
      for (int i = 1; i <= r.n; i++) begin
         e.sel  = r.sel;
         e.outd = r.outd;
         e.ack  = r.ack;
         e.cen  = (((ncyc + i) % PRESCALE) == PRESCALE - 1);
         sb.push_back(e);
      end
      for (int i = 0; i < r.n; i++) begin
         @(posedge Clk);
         ncyc++;
         #1;
         e = sb.pop_front();
         checks++;
         if (Sel !== e.sel || OutD !== e.outd || Hold_ack !== e.ack || Cen !== e.cen) begin
            errors++;
            $display("FAIL row%0d cyc%0d: got sel=%0d outd=%02h ack=%0b cen=%0b, want sel=%0d outd=%02h ack=%0b cen=%0b",
                     id, ncyc, Sel, OutD, Hold_ack, Cen, e.sel, e.outd, e.ack, e.cen);
         end
      end
   endtask

   task automatic chk_zero(input string nm);
      checks++;
      if (Sel !== 2'd0 || OutD !== 8'h00 || Hold_ack !== 1'b0 || Cen !== 1'b0) begin
         errors++;
         $display("FAIL %s: got sel=%0d outd=%02h ack=%0b cen=%0b, want all zero",
                  nm, Sel, OutD, Hold_ack, Cen);
      end
   endtask

   initial begin
      row_t post;
      Src0 = 8'h11; Src1 = 8'h22; Src2 = 8'h33; Src3 = 8'h44;
      Src_en = 4'b0000; Hold_req = 1'b0; Hold_src = 2'd0;

      // idle: Cen ticks, display dark
      add(4'b0000, 1'b0, 2'd0, 12, 2'd0, 8'h00, 1'b0);
      // rotation over 0,1,3
      add(4'b1011, 1'b0, 2'd0,  1, 2'd0, 8'h00, 1'b0);
      add(4'b1011, 1'b0, 2'd0,  6, 2'd0, 8'h11, 1'b0);
`ifdef DISP_BLANK_EN
      add(4'b1011, 1'b0, 2'd0,  1, 2'd1, 8'h11, 1'b0);
      add(4'b1011, 1'b0, 2'd0,  4, 2'd1, 8'h00, 1'b0);
      add(4'b1011, 1'b0, 2'd0,  7, 2'd1, 8'h22, 1'b0);
      add(4'b1011, 1'b0, 2'd0,  1, 2'd3, 8'h22, 1'b0);
      add(4'b1011, 1'b0, 2'd0,  4, 2'd3, 8'h00, 1'b0);
      add(4'b1011, 1'b0, 2'd0,  7, 2'd3, 8'h44, 1'b0);
      add(4'b1011, 1'b0, 2'd0,  1, 2'd0, 8'h44, 1'b0);
      add(4'b1011, 1'b0, 2'd0,  4, 2'd0, 8'h00, 1'b0);
      add(4'b1011, 1'b0, 2'd0,  7, 2'd0, 8'h11, 1'b0);
`else
      add(4'b1011, 1'b0, 2'd0,  1, 2'd1, 8'h11, 1'b0);
      add(4'b1011, 1'b0, 2'd0,  7, 2'd1, 8'h22, 1'b0);
      add(4'b1011, 1'b0, 2'd0,  1, 2'd3, 8'h22, 1'b0);
      add(4'b1011, 1'b0, 2'd0,  7, 2'd3, 8'h44, 1'b0);
      add(4'b1011, 1'b0, 2'd0,  1, 2'd0, 8'h44, 1'b0);
      add(4'b1011, 1'b0, 2'd0,  7, 2'd0, 8'h11, 1'b0);
      add(4'b1011, 1'b0, 2'd0,  1, 2'd1, 8'h11, 1'b0);
      add(4'b1011, 1'b0, 2'd0,  2, 2'd1, 8'h22, 1'b0);
      // hold on disabled source 2 across 5 Cen pulses, release resumes at 3
      add(4'b1011, 1'b1, 2'd2,  1, 2'd2, 8'h22, 1'b1);
      add(4'b1011, 1'b1, 2'd2, 20, 2'd2, 8'h33, 1'b1);
      add(4'b1011, 1'b0, 2'd2,  1, 2'd3, 8'h33, 1'b0);
      add(4'b1011, 1'b0, 2'd2,  7, 2'd3, 8'h44, 1'b0);
      add(4'b1011, 1'b0, 2'd2,  1, 2'd0, 8'h44, 1'b0);
      add(4'b1011, 1'b0, 2'd2,  7, 2'd0, 8'h11, 1'b0);
      // hold request on the dwell-expiry edge wins
      add(4'b1011, 1'b1, 2'd2,  1, 2'd2, 8'h11, 1'b1);
      add(4'b1011, 1'b1, 2'd2,  2, 2'd2, 8'h33, 1'b1);
      add(4'b1011, 1'b1, 2'd0,  1, 2'd0, 8'h33, 1'b1);
      add(4'b1011, 1'b1, 2'd0,  1, 2'd0, 8'h11, 1'b1);
      add(4'b1011, 1'b0, 2'd0,  1, 2'd0, 8'h11, 1'b0);
      // selected source disabled mid-scan
      add(4'b1010, 1'b0, 2'd0,  1, 2'd1, 8'h11, 1'b0);
      add(4'b1010, 1'b0, 2'd0,  5, 2'd1, 8'h22, 1'b0);
      add(4'b1010, 1'b0, 2'd0,  1, 2'd3, 8'h22, 1'b0);
      add(4'b1010, 1'b0, 2'd0,  2, 2'd3, 8'h44, 1'b0);
      // all disabled -> idle, then hold from idle beats Src_en
      add(4'b0000, 1'b0, 2'd0,  1, 2'd3, 8'h44, 1'b0);
      add(4'b0000, 1'b0, 2'd0,  2, 2'd3, 8'h00, 1'b0);
      add(4'b1011, 1'b1, 2'd1,  1, 2'd1, 8'h00, 1'b1);
      add(4'b1011, 1'b1, 2'd1,  1, 2'd1, 8'h22, 1'b1);
      add(4'b1011, 1'b0, 2'd1,  1, 2'd1, 8'h22, 1'b0);
      add(4'b1011, 1'b0, 2'd1,  2, 2'd1, 8'h22, 1'b0);
      add(4'b1011, 1'b1, 2'd3,  1, 2'd3, 8'h22, 1'b1);
      add(4'b1011, 1'b1, 2'd3,  4, 2'd3, 8'h44, 1'b1);
`endif

      repeat (2) @(posedge Clk);
      #1;
      chk_zero("reset_state");
      #2 Rst_n = 1'b1;
      ncyc = 0;

      foreach (tbl[k]) run_row(tbl[k], k);

      // asynchronous reset between edges, held across one edge
      #2 Rst_n = 1'b0;
      #1 chk_zero("async_reset");
      Hold_req = 1'b0;
      Src_en   = 4'b0000;
      @(posedge Clk);
      #1 chk_zero("reset_held");
      #2 Rst_n = 1'b1;
      ncyc = 0;
      post.en = 4'b0000; post.hreq = 1'b0; post.hsrc = 2'd0; post.n = 8;
      post.sel = 2'd0; post.outd = 8'h00; post.ack = 1'b0;
      run_row(post, 99);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
